// File: rtl/clarke_park.sv
// Clarke/Park transform: raw phase-current ADC codes plus sin/cos of the electrical
// angle in, saturated d/q currents out, using one shared multiplier over a fixed 8-cycle sequence.
module clarke_park #(
  parameter logic        [11:0] OFFSET_U    = 12'd2048,
  parameter logic        [11:0] OFFSET_V    = 12'd2048,
  parameter logic signed [15:0] K_INV_SQRT3 = 16'sd18919
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iStart,
  input  logic        [11:0] iIu,
  input  logic        [11:0] iIv,
  input  logic signed [15:0] iSin,
  input  logic signed [15:0] iCos,
  output logic signed [12:0] oId,
  output logic signed [12:0] oIq,
  output logic               oBusy,
  output logic               oDone,
  output logic               oSat,
  output logic        [2:0]  oState
);

  // Handshake: iStart is sampled only in IDLE; an accepted start raises oBusy on
  // that edge, oDone pulses for one cycle seven edges later with oId/oIq/oSat
  // updated on the same edge, and oBusy drops on the following edge unless a
  // new start is sampled there. Starts seen outside IDLE are dropped, not queued.
  typedef enum logic [2:0] {
    S_IDLE, S_CLARKE, S_BETA, S_M0, S_M1, S_M2, S_M3, S_OUT
  } state_t;

  state_t             r_state;
  logic        [11:0] r_iu, r_iv;
  logic signed [15:0] r_sin, r_cos;
  logic signed [12:0] r_ia, r_ib;
  logic signed [14:0] r_sum;
  logic signed [30:0] r_acc_d, r_acc_q;

  logic signed [12:0] w_ia, w_ib;
  logic signed [14:0] w_sum;
  logic signed [14:0] w_mul_a;
  logic signed [15:0] w_mul_b;
  logic signed [30:0] w_prod, w_beta_rnd;
  logic        [13:0] w_rd, w_rq;

  assign oState = r_state;

  // Offsets are removed modulo 2^13, which yields the two's-complement difference.
  assign w_ia  = {1'b0, r_iu} - {1'b0, OFFSET_U};
  assign w_ib  = {1'b0, r_iv} - {1'b0, OFFSET_V};
  assign w_sum = {{2{w_ia[12]}}, w_ia} + {w_ib[12], w_ib, 1'b0};

  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_BETA: begin w_mul_a = r_sum;                     w_mul_b = K_INV_SQRT3; end
      S_M0:   begin w_mul_a = {{2{r_ia[12]}}, r_ia};     w_mul_b = r_cos;       end
      S_M1:   begin w_mul_a = {{2{r_ib[12]}}, r_ib};     w_mul_b = r_sin;       end
      S_M2:   begin w_mul_a = {{2{r_ia[12]}}, r_ia};     w_mul_b = r_sin;       end
      S_M3:   begin w_mul_a = {{2{r_ib[12]}}, r_ib};     w_mul_b = r_cos;       end
      default: ;
    endcase
  end

  assign w_prod     = 31'(w_mul_a) * 31'(w_mul_b);
  assign w_beta_rnd = w_prod + 31'sd16384;

  // Round half up at bit 14, then clip to the 13-bit range; bit 13 flags a clip.
  function automatic logic [13:0] round_sat(input logic signed [30:0] acc);
    logic signed [30:0] t;
    logic signed [16:0] r;
    t = acc + 31'sd8192;
    r = t[30:14];
    if (r > 17'sd4095)       return {1'b1, 13'h0FFF};
    else if (r < -17'sd4096) return {1'b1, 13'h1000};
    else                     return {1'b0, r[12:0]};
  endfunction

  assign w_rd = round_sat(r_acc_d);
  assign w_rq = round_sat(r_acc_q);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_iu    <= '0;
      r_iv    <= '0;
      r_sin   <= '0;
      r_cos   <= '0;
      r_ia    <= '0;
      r_ib    <= '0;
      r_sum   <= '0;
      r_acc_d <= '0;
      r_acc_q <= '0;
      oId     <= '0;
      oIq     <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oSat    <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          oBusy <= iStart;
          if (iStart) begin
            r_iu    <= iIu;
            r_iv    <= iIv;
            r_sin   <= iSin;
            r_cos   <= iCos;
            r_state <= S_CLARKE;
          end
        end
        S_CLARKE: begin
          r_ia    <= w_ia;
          r_sum   <= w_sum;
          r_state <= S_BETA;
        end
        S_BETA: begin
          r_ib    <= w_beta_rnd[27:15];
          r_state <= S_M0;
        end
        S_M0: begin
          r_acc_d <= w_prod;
          r_state <= S_M1;
        end
        S_M1: begin
          r_acc_d <= r_acc_d + w_prod;
          r_state <= S_M2;
        end
        S_M2: begin
          r_acc_q <= -w_prod;
          r_state <= S_M3;
        end
        S_M3: begin
          r_acc_q <= r_acc_q + w_prod;
          r_state <= S_OUT;
        end
        S_OUT: begin
          oId     <= w_rd[12:0];
          oIq     <= w_rq[12:0];
          oSat    <= w_rd[13] | w_rq[13];
          oDone   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clarke_park.sv
// Directed and randomized bench for clarke_park against an integer-arithmetic
// reference of the Clarke/Park equations, with timing checks on busy/done.
module tb_clarke_park;

  logic               iClk = 1'b0;
  logic               iRst_n;
  logic               iStart;
  logic        [11:0] iIu, iIv;
  logic        [15:0] iSin, iCos;
  logic        [12:0] oId, oIq;
  logic               oBusy, oDone, oSat;
  logic        [2:0]  oState;

  int n_checks = 0;
  int n_err    = 0;
  logic [26:0] exp_q[$];

  clarke_park dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iStart (iStart),
    .iIu    (iIu),
    .iIv    (iIv),
    .iSin   (iSin),
    .iCos   (iCos),
    .oId    (oId),
    .oIq    (oIq),
    .oBusy  (oBusy),
    .oDone  (oDone),
    .oSat   (oSat),
    .oState (oState)
  );

  always #5 iClk = ~iClk;

  // Reference: {sat, d, q} straight from the transform equations.
  function automatic logic [26:0] model(input int iu, input int iv, input int s, input int c);
    longint ia, ib, sum, beta, d, q, rd, rq;
    logic sat;
    ia   = iu - 2048;
    ib   = iv - 2048;
    sum  = ia + 2 * ib;
    beta = (sum * 18919 + 16384) >>> 15;
    d    = ia * c + beta * s;
    q    = beta * c - ia * s;
    rd   = (d + 8192) >>> 14;
    rq   = (q + 8192) >>> 14;
    sat  = 1'b0;
    if (rd > 4095)  begin rd = 4095;  sat = 1'b1; end
    if (rd < -4096) begin rd = -4096; sat = 1'b1; end
    if (rq > 4095)  begin rq = 4095;  sat = 1'b1; end
    if (rq < -4096) begin rq = -4096; sat = 1'b1; end
    return {sat, 13'(rd), 13'(rq)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input int iu, input int iv, input int s, input int c);
    iIu  = 12'(iu);
    iIv  = 12'(iv);
    iSin = 16'(s);
    iCos = 16'(c);
  endtask

  task automatic scramble();
    iIu  = 12'($urandom);
    iIv  = 12'($urandom);
    iSin = 16'($urandom);
    iCos = 16'($urandom);
  endtask

  // Step through the remaining busy cycles, then check the done cycle and results.
  task automatic finish_run(input int mid_steps, input string tag);
    logic [26:0] e;
    for (int k = 0; k < mid_steps; k++) begin
      step();
      chk({tag, "_done_early"}, oDone, 0);
    end
    step();
    chk({tag, "_done"}, oDone, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_exp_q_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_id"},  oId,  e[25:13]);
      chk({tag, "_iq"},  oIq,  e[12:0]);
      chk({tag, "_sat"}, oSat, e[26]);
    end
  endtask

  task automatic run(input int iu, input int iv, input int s, input int c, input string tag);
    exp_q.push_back(model(iu, iv, s, c));
    drive(iu, iv, s, c);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    scramble();
    chk({tag, "_busy_rise"}, oBusy, 1);
    finish_run(6, tag);
    step();
    chk({tag, "_done_fall"}, oDone, 0);
    chk({tag, "_busy_fall"}, oBusy, 0);
  endtask

  initial begin
    logic saw_done;
    int iu, iv, s, c;
    iRst_n = 1'b0;
    iStart = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) step();
    chk("rst_id",   oId,   0);
    chk("rst_iq",   oIq,   0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    chk("rst_sat",  oSat,  0);
    iRst_n = 1'b1;
    step();

    run(2048, 2048, 0, 16384, "zero");
    run(3048, 1548, 0, 16384, "theta0");
    run(3048, 1548, 16384, 0, "theta90");
    run(2048, 3048, 0, 16384, "beta_round");
    run(0, 0, 32767, 32767, "sat");
    run(2048, 2048, 0, 16384, "sat_clear");
    run(4095, 4095, -32768, -32768, "corner");

    for (int i = 0; i < 16; i++) begin
      iu = int'($urandom_range(0, 4095));
      iv = int'($urandom_range(0, 4095));
      s  = int'($urandom_range(0, 65535)) - 32768;
      c  = int'($urandom_range(0, 65535)) - 32768;
      run(iu, iv, s, c, "rand");
    end

    // A start pulse at N+3 must be dropped.
    exp_q.push_back(model(1000, 3000, 12000, -7000));
    drive(1000, 3000, 12000, -7000);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    scramble();
    step();
    step();
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    finish_run(3, "ignore");
    step();
    chk("ignore_busy_fall", oBusy, 0);
    chk("ignore_state_idle", oState, 0);

    // Start held high: restarts at N+8 with fresh inputs, done at N+15.
    exp_q.push_back(model(2548, 2048, 8000, -9000));
    drive(2548, 2048, 8000, -9000);
    iStart = 1'b1;
    step();
    scramble();
    finish_run(6, "b2b_a");
    exp_q.push_back(model(3048, 1548, 0, 16384));
    drive(3048, 1548, 0, 16384);
    step();
    chk("b2b_busy_hold", oBusy, 1);
    chk("b2b_done_low",  oDone, 0);
    iStart = 1'b0;
    scramble();
    finish_run(6, "b2b_b");
    step();
    chk("b2b_busy_fall", oBusy, 0);

    // Reset at N+4 aborts the transform without a done.
    drive(2048, 3048, 0, 16384);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    step();
    step();
    step();
    iRst_n = 1'b0;
    #1;
    chk("abort_id",   oId,   0);
    chk("abort_iq",   oIq,   0);
    chk("abort_busy", oBusy, 0);
    chk("abort_done", oDone, 0);
    chk("abort_sat",  oSat,  0);
    step();
    step();
    iRst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (oDone) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    run(3048, 1548, 16384, 0, "after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/clarke_park.md
# clarke_park

Current-frame transform stage directly downstream of the data-acquisition block. It takes the two raw 12-bit phase-current ADC codes (Iu, Iv) and the CORDIC sine/cosine of the electrical angle. It outputs signed d/q-axis currents for the current-loop PI regulators. A single shared signed multiplier is time-multiplexed by a fixed-sequence state machine, with a start/done handshake.

## Interface
- OFFSET_U, 12'd2048, ADC zero-current code for phase U
- OFFSET_V, 12'd2048, ADC zero-current code for phase V
- K_INV_SQRT3, 16'sd18919, 1/√3 in signed Q1.15
- iClk  in  1  system clock
- iRst_n  in  1  reset, asynchronous, active-low
- iStart  in  1  start pulse (driven by ADC acquire-done)
- iIu  in  12  phase U ADC code, unsigned
- iIv  in  12  phase V ADC code, unsigned
- iSin  in  16  sin θe, signed Q2.14 (16384 = 1.0)
- iCos  in  16  cos θe, signed Q2.14
- oId  out  13  d-axis current, signed, ADC LSB units
- oIq  out  13  q-axis current, signed
- oBusy  out  1  high from accepted start until done
- oDone  out  1  one-cycle pulse, results valid
- oSat  out  1  saturation occurred in last transform (held)

## Operation
- States: IDLE, CLARKE, BETA, M0, M1, M2, M3, OUT.
- IDLE: if iStart is high, latch iIu, iIv, iSin, iCos into internal registers, then go to CLARKE. Input changes after the latch have no effect.
- CLARKE:
  - Ia = Iu − OFFSET_U, Ib = Iv − OFFSET_V (13-bit signed).
  - sum = Ia + 2·Ib (15-bit signed).
  - Iα = Ia.
- BETA: Iβ = (sum·K + 2^14) >>> 15 (arithmetic shift, round half up), 13-bit signed.
- M0: accD = Iα·cos.
- M1: accD += Iβ·sin.
- M2: accQ = −(Iα·sin).
- M3: accQ += Iβ·cos.
- Products are 13×16 → 29-bit signed. Accumulators are 31-bit signed.
- OUT:
  - r = (acc + 2^13) >>> 14.
  - Saturate r to [−4096, 4095]. Register the results into oId and oIq.
  - oSat = 1 if either value clipped, else 0.
  - oDone = 1, then return to IDLE.
- The multiplier is shared, with exactly one multiply per cycle in BETA and M0–M3.
- iStart while not in IDLE (including the OUT cycle) is ignored, not queued.

## Timing
- Reset values: oId = 0, oIq = 0, oBusy = 0, oDone = 0, oSat = 0. State = IDLE. All internal registers = 0.
- Reset asserted mid-sequence aborts immediately. No oDone is produced, and the outputs take their reset values.
- iStart sampled high at edge N (state IDLE) → oBusy high after edge N.
- oDone high for exactly one cycle after edge N+7. oId, oIq, and oSat are updated at the same edge.
- oBusy falls at edge N+8.
- Minimum start-to-start spacing: 8 cycles. iStart at edge N+8 is accepted.
- oId, oIq, and oSat hold their values until the next OUT state.
- iStart may be a level or a pulse. Only IDLE-state samples count, so a level held high restarts every 8 cycles.

## Test plan
- Zero current: Iu = Iv = 2048, sin = 0, cos = 16384 → oId = 0, oIq = 0, oSat = 0. oDone at edge N+7.
- θ = 0: Iu = 3048, Iv = 1548 (Ia = 1000, Ib = −500, Iβ = 0), sin = 0, cos = 16384 → oId = 1000, oIq = 0.
- θ = 90°: same currents, sin = 16384, cos = 0 → oId = 0, oIq = −1000.
- Iβ rounding: Iu = 2048, Iv = 3048 (sum = 2000), sin = 0, cos = 16384 → Iβ = 1155, oId = 0, oIq = 1155.
- Saturation: Iu = 0, Iv = 0, sin = cos = 32767 → Iβ = −3547, oId = −4096, oSat = 1. A following zero-current run clears oSat to 0.
- Handshake:
  - iStart pulsed at N+3 is ignored. iStart at N+8 is accepted, with oDone at N+15.
  - iRst_n low at N+4 → outputs 0, no oDone.
  - After release, a start completes normally.
